hazard_sched: RTL
=================

Name: hazard_sched

Overview:
- Issue scheduler for the 4-stage SIMD pipeline: fetch, decode, execute, memory-writeback, then the chip write-port pipe.
- Keeps a per-register scoreboard of in-flight writes and stalls decode on RAW hazards.
- Holds issue while a PC-writing instruction travels to the memory stage, then flushes the wrong-path fetch/decode word if the branch is taken.
- Sits beside the decode stage; drives the fetch/decode pipe hold, the decode/execute bubble and the fetch/decode flush.

Parameters:
SEL_BITS, 4, register-select width (matches rSel1/rSel2/RegToWrite)
REG_COUNT, 16, scoreboard entries, equals 2**SEL_BITS
CNT_W, 2, per-register pending counter width (max 3 in flight: execute, memory, chip)
STAT_W, 16, stall statistics counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
dec_valid  in  1  decode holds a real instruction
dec_rs1  in  SEL_BITS  operand-1 select
dec_rs2  in  SEL_BITS  operand-2 select
dec_rs1_used  in  1  instruction reads rs1
dec_rs2_used  in  1  instruction reads rs2
dec_rd  in  SEL_BITS  destination (RegToWrite)
dec_wr  in  1  RegWriteEnSc OR RegWriteEnVec
dec_branch  in  1  decoded PcWriteEn != 0
br_taken  in  1  PC write at memory stage (PCWrEn)
wb_wr  in  1  chip-stage register write (regWriteEnSc OR regWriteEnVec)
wb_rd  in  SEL_BITS  chip-stage RegToWrite
hold_fd  out  1  freeze PC and fetch/decode pipe
bubble_de  out  1  load all-zero control bundle into decode/execute pipe
flush_fd  out  1  clear fetch/decode pipe
issue  out  1  decode instruction advances this cycle
busy  out  1  any scoreboard counter non-zero
sb_err  out  1  sticky: retire to a zero counter, or increment of a saturated counter
stall_cnt  out  STAT_W  cycles with hold_fd=1, saturating

Behaviour:
Reset (rst=0 at posedge):
- All counters 0, FSM=IDLE, sb_err=0, stall_cnt=0.
- Outputs during reset: hold_fd=0, bubble_de=0, flush_fd=0, issue=0.

Hazard and issue (combinational, zero latency, from registered state plus current decode inputs):
- raw = (dec_rs1_used & pend[dec_rs1]!=0) | (dec_rs2_used & pend[dec_rs2]!=0).
- stall = dec_valid & (raw | state!=IDLE).
- issue = dec_valid & !stall.
- hold_fd = stall.
- bubble_de = stall | (dec_valid=0).

Scoreboard update (posedge):
- inc = issue & dec_wr; dec = wb_wr.
- Same register with inc and dec together: count unchanged.
- dec on a zero count: stays 0, sb_err set.
- inc on count 3: saturates, sb_err set.
- Retire in cycle N clears the hazard from cycle N+1. There is no same-cycle bypass.
- Self-dependency (rs==rd) checks the old count, before the increment.

Branch FSM (states IDLE, BR_EX, BR_MEM):
- IDLE -> BR_EX when issue & dec_branch.
- BR_EX -> BR_MEM unconditionally. Branch is in execute; stall asserted.
- BR_MEM -> IDLE unconditionally. Branch is in memory; stall asserted.
- In BR_MEM: flush_fd = br_taken. The fetch PC write takes priority over hold_fd.
- Not taken: no flush; the held instruction issues in the next IDLE cycle.
- br_taken outside BR_MEM: ignored and sb_err set.

stall_cnt:
- +1 each cycle hold_fd=1, saturating at all-ones.

Reset mid-operation:
- Synchronous clear overrides any FSM state or pending count in the same edge.

Decomposition:
- Shared package hazard_pkg: sched_state_t enum (IDLE, BR_EX, BR_MEM), SEL_BITS/CNT_W defaults, a typedef for the decode request bundle.
- One sub-module, sb_counter: a single saturating up/down pending counter with error flag, instantiated REG_COUNT times by generate.

Test Plan:
1. Reset 2 cycles, then dec_valid=1, rs1=2, rs2=3, rd=5, dec_wr=1, all counts 0 -> issue=1, hold_fd=0. Next cycle pend[5]=1, busy=1.
2. Issue writer rd=5. Next cycle dec_rs1=5, rs1_used=1 -> hold_fd=1, bubble_de=1. After wb_wr=1, wb_rd=5 at cycle N, issue=1 at N+1; stall_cnt equals the stall length (3 for back-to-back).
3. Branch issued (dec_branch=1) with br_taken=1 two cycles later -> hold_fd=1 for exactly 2 cycles, flush_fd=1 only in the BR_MEM cycle, FSM back to IDLE.
4. Same branch with br_taken=0 -> flush_fd never asserts; following instruction issues in cycle 3.
5. Same cycle: issue rd=7 with wb_wr to rd=7, pend[7]=1 -> pend[7] stays 1. wb_wr rd=9 with pend[9]=0 -> sb_err=1 and stays 1 until reset.
6. rst=0 asserted during BR_EX with pend[4]=2 -> next cycle state IDLE, busy=0, stall_cnt=0, all outputs at reset values.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and sizing for the SIMD issue scheduler.
// Register selects, the scoreboard geometry and the branch-tracking states live here.
package hazard_pkg;

   localparam int unsigned SEL_BITS  = 4;
   localparam int unsigned REG_COUNT = 2 ** SEL_BITS;
   localparam int unsigned CNT_W     = 2;
   localparam int unsigned STAT_W    = 16;

   typedef logic [SEL_BITS-1:0] sel_t;

   typedef enum logic [1:0] {
      StIdle,
      StBrEx,
      StBrMem
   } sched_state_t;

   typedef struct packed {
      logic valid;
      sel_t rs1;
      sel_t rs2;
      logic rs1_used;
      logic rs2_used;
      sel_t rd;
      logic wr;
      logic branch;
   } dec_req_t;

endpackage

// File: rtl/hazard_sched_if.sv
// Signal bundle between the decode stage (master) and the issue scheduler (slave).
interface hazard_sched_if;
   import hazard_pkg::*;

   logic              dec_valid;
   sel_t              dec_rs1;
   sel_t              dec_rs2;
   logic              dec_rs1_used;
   logic              dec_rs2_used;
   sel_t              dec_rd;
   logic              dec_wr;
   logic              dec_branch;
   logic              br_taken;
   logic              wb_wr;
   sel_t              wb_rd;
   logic              hold_fd;
   logic              bubble_de;
   logic              flush_fd;
   logic              issue;
   logic              busy;
   logic              sb_err;
   logic [STAT_W-1:0] stall_cnt;

   modport master (
      output dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used, dec_rd, dec_wr,
             dec_branch, br_taken, wb_wr, wb_rd,
      input  hold_fd, bubble_de, flush_fd, issue, busy, sb_err, stall_cnt
   );

   modport slave (
      input  dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used, dec_rd, dec_wr,
             dec_branch, br_taken, wb_wr, wb_rd,
      output hold_fd, bubble_de, flush_fd, issue, busy, sb_err, stall_cnt
   );

endinterface

// File: rtl/sb_counter.sv
// One scoreboard entry: saturating up/down count of in-flight writes to a register.
// err_o pulses for a retire from zero or an increment past the maximum.
module sb_counter
   import hazard_pkg::*;
#(
   parameter int unsigned Width = CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [Width-1:0] count_o,
   output logic             err_o
);

   logic [Width-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      err_o   = 1'b0;
      if (inc_i && !dec_i) begin
         if (&count_q) err_o = 1'b1;
         else          count_d = count_q + Width'(1);
      end else if (dec_i && !inc_i) begin
         if (count_q == '0) err_o = 1'b1;
         else               count_d = count_q - Width'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) count_q <= '0;
      else         count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/hazard_sched.sv
// Issue scheduler beside decode: RAW scoreboard stall plus a hold while a PC-writing
// instruction travels to memory, with a wrong-path flush when the branch is taken.
module hazard_sched
   import hazard_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   hazard_sched_if.slave  bus
);

   dec_req_t                          req;
   sched_state_t                      state_q, state_d;
   logic                              sb_err_q, sb_err_d;
   logic [STAT_W-1:0]                 stall_cnt_q, stall_cnt_d;
   logic [REG_COUNT-1:0][CNT_W-1:0]   pend;
   logic [REG_COUNT-1:0]              inc_vec, dec_vec, cnt_err;
   logic                              valid, raw, stall, issue, br_err;

   assign req = '{valid:    bus.dec_valid,
                  rs1:      bus.dec_rs1,
                  rs2:      bus.dec_rs2,
                  rs1_used: bus.dec_rs1_used,
                  rs2_used: bus.dec_rs2_used,
                  rd:       bus.dec_rd,
                  wr:       bus.dec_wr,
                  branch:   bus.dec_branch};

   // Gating with rst keeps every pipe control quiet while reset is held.
   assign valid = req.valid & rst;
   assign raw   = (req.rs1_used & (pend[req.rs1] != '0)) |
                  (req.rs2_used & (pend[req.rs2] != '0));
   assign stall = valid & (raw | (state_q != StIdle));
   assign issue = valid & ~stall;

   for (genvar i = 0; i < REG_COUNT; i++) begin : g_cnt
      assign inc_vec[i] = issue & req.wr & (req.rd == sel_t'(i));
      assign dec_vec[i] = bus.wb_wr & (bus.wb_rd == sel_t'(i));

      sb_counter #(
         .Width (CNT_W)
      ) u_cnt (
         .clk_i   (clk),
         .rst_ni  (rst),
         .inc_i   (inc_vec[i]),
         .dec_i   (dec_vec[i]),
         .count_o (pend[i]),
         .err_o   (cnt_err[i])
      );
   end

   assign br_err = bus.br_taken & (state_q != StBrMem);

   always_comb begin
      state_d     = state_q;
      sb_err_d    = sb_err_q | (|cnt_err) | br_err;
      stall_cnt_d = stall_cnt_q;
      if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + STAT_W'(1);
      unique case (state_q)
         StIdle:  if (issue && req.branch) state_d = StBrEx;
         StBrEx:  state_d = StBrMem;
         StBrMem: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         sb_err_q    <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         sb_err_q    <= sb_err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.hold_fd   = stall;
   assign bus.bubble_de = rst & (stall | ~req.valid);
   assign bus.flush_fd  = rst & (state_q == StBrMem) & bus.br_taken;
   assign bus.issue     = issue;
   assign bus.busy      = |pend;
   assign bus.sb_err    = sb_err_q;
   assign bus.stall_cnt = stall_cnt_q;

endmodule
